// File: rtl/score_pkg.sv
// Shared constants, BCD nibble type and conversion FSM states for score_bcd_counter.
package score_pkg;

   localparam int unsigned SCORE_WIDTH  = 14;
   localparam int unsigned MAX_SCORE    = 9999;
   localparam int unsigned POINTS_WIDTH = 4;
   localparam int unsigned DIGITS       = 4;

   typedef logic [3:0] bcd_nibble_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_e;

   // Shift counter must reach SCORE_WIDTH-1.
   function automatic int unsigned cnt_width(input int unsigned score_w);
      return $clog2(score_w + 1);
   endfunction

   localparam int unsigned CNT_WIDTH = cnt_width(SCORE_WIDTH);

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble per-nibble correction: a BCD nibble of 5 or more gets 3 added before the shift.
module bcd_add3
   import score_pkg::*;
(
   input  bcd_nibble_t nib_i,
   output bcd_nibble_t nib_o_c
);

   always_comb begin
      nib_o_c = nib_i;
      if (nib_i >= 4'd5) nib_o_c = nib_i + 4'd3;
   end

endmodule

// File: rtl/score_bcd_counter.sv
// Saturating score accumulator with iterative binary-to-BCD conversion and atomic digit commit.
// Optional leading-zero blanking mask enabled by defining SCORE_LEADING_BLANK_EN.
module score_bcd_counter #(
   parameter int unsigned SCORE_WIDTH  = score_pkg::SCORE_WIDTH,
   parameter int unsigned MAX_SCORE    = score_pkg::MAX_SCORE,
   parameter int unsigned POINTS_WIDTH = score_pkg::POINTS_WIDTH,
   parameter int unsigned DIGITS       = score_pkg::DIGITS
) (
   input  logic                    iVGA_CLK,
   input  logic                    iRST,
   input  logic                    iClear,
   input  logic                    iAdd_Valid,
   input  logic [POINTS_WIDTH-1:0] iAdd_Points,
   output logic [SCORE_WIDTH-1:0]  oScore,
   output logic [DIGITS*4-1:0]     oDigits,
   output logic                    oUpdate,
   output logic                    oBusy,
   output logic                    oSat,
   output logic [DIGITS-1:0]       oBlank
);

   import score_pkg::state_e;
   import score_pkg::IDLE;
   import score_pkg::SHIFT;
   import score_pkg::COMMIT;
   import score_pkg::cnt_width;

   localparam int unsigned BCD_W = DIGITS * 4;
   localparam int unsigned SR_W  = BCD_W + SCORE_WIDTH;
   localparam int unsigned CNT_W = cnt_width(SCORE_WIDTH);
   localparam int unsigned SUM_W = SCORE_WIDTH + 1;

   state_e                   state_q, state_d;
   logic [SCORE_WIDTH-1:0]   score_q, score_d;
   logic                     sat_q, sat_d;
   logic                     dirty_q, dirty_d;
   logic [SR_W-1:0]          sr_q, sr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [BCD_W-1:0]         digits_q, digits_d;
   logic                     update_q, update_d;
   logic                     busy_q, busy_d;
   logic [SR_W-1:0]          sr_adj_c;
   logic [SUM_W-1:0]         sum_c;

   // Correct every BCD nibble above the binary part, then shift as one word.
   assign sr_adj_c[SCORE_WIDTH-1:0] = sr_q[SCORE_WIDTH-1:0];
   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
      bcd_add3 u_add3 (
         .nib_i   (sr_q[SCORE_WIDTH + 4*g +: 4]),
         .nib_o_c (sr_adj_c[SCORE_WIDTH + 4*g +: 4])
      );
   end

   assign sum_c = {1'b0, score_q} + SUM_W'(iAdd_Points);

   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      sat_d    = sat_q;
      dirty_d  = dirty_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      digits_d = digits_q;
      update_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (dirty_q) begin
               sr_d    = {{BCD_W{1'b0}}, score_q};
               cnt_d   = '0;
               dirty_d = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = {sr_adj_c[SR_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SCORE_WIDTH - 1)) state_d = COMMIT;
         end
         COMMIT: begin
            digits_d = sr_q[SR_W-1 -: BCD_W];
            update_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Adds after the FSM so an add coinciding with a load re-arms dirty.
      if (iAdd_Valid) begin
         dirty_d = 1'b1;
         if (sum_c > SUM_W'(MAX_SCORE)) begin
            score_d = SCORE_WIDTH'(MAX_SCORE);
            sat_d   = 1'b1;
         end else begin
            score_d = sum_c[SCORE_WIDTH-1:0];
         end
      end

      if (iClear) begin
         state_d  = IDLE;
         score_d  = '0;
         sat_d    = 1'b0;
         dirty_d  = 1'b0;
         digits_d = '0;
         update_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge iVGA_CLK) begin
      if (iRST) begin
         state_q  <= IDLE;
         score_q  <= '0;
         sat_q    <= 1'b0;
         dirty_q  <= 1'b0;
         sr_q     <= '0;
         cnt_q    <= '0;
         digits_q <= '0;
         update_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         score_q  <= score_d;
         sat_q    <= sat_d;
         dirty_q  <= dirty_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         digits_q <= digits_d;
         update_q <= update_d;
         busy_q   <= busy_d;
      end
   end

`ifdef SCORE_LEADING_BLANK_EN
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   logic [DIGITS-1:0] blank_q, blank_d;

   // A digit blanks when it and every higher digit are zero; digit 0 always shows.
   always_comb begin
      logic upper_zero;
      blank_d    = '0;
      upper_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         upper_zero = upper_zero & (digits_d[4*i +: 4] == 4'd0);
         blank_d[i] = upper_zero;
      end
   end

   always_ff @(posedge iVGA_CLK) begin
      if (iRST) blank_q <= BLANK_RST;
      else      blank_q <= blank_d;
   end

   assign oBlank = blank_q;
`else
   assign oBlank = '0;
`endif

   assign oScore  = score_q;
   assign oDigits = digits_q;
   assign oUpdate = update_q;
   assign oBusy   = busy_q;
   assign oSat    = sat_q;

endmodule
